// File: rtl/mcu_io_pkg.sv
// Shared constants for the MCU I/O port blocks.
// Button port sizing and the default debounce qualification length live here.
package mcu_io_pkg;

  localparam int NUM_BTN          = 4;
  localparam int DEFAULT_DB_COUNT = 500000;

  // CPU input-port map for the I/O blocks on this bus
  localparam logic [7:0] BTN_EVENT_PORT_ADDR = 8'h20;
  localparam logic [7:0] BTN_LEVEL_PORT_ADDR = 8'h21;

endpackage

// File: rtl/btn_event_port_if.sv
// CPU-side port of the button event block: read strobe, event flags, interrupt.
interface btn_event_port_if;
  import mcu_io_pkg::*;

  logic               RD;
  logic [NUM_BTN-1:0] DOUT;
  logic               INTR;

  modport master (output RD, input DOUT, input INTR);
  modport slave  (input RD, output DOUT, output INTR);

endinterface

// File: rtl/btn_event_port_debounce_bit.sv
// One button bit: 2-flop synchronizer, stability counter and debounced level.
// RISE is combinational and marks the edge on which LEVEL will go 0->1.
module debounce_bit
  import mcu_io_pkg::*;
#(
  parameter int DB_COUNT = DEFAULT_DB_COUNT
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic LEVEL,
  output logic RISE
);

  localparam int            CW       = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          differ;
  logic          done;

  assign differ = sync_q[1] ^ level_q;
  assign done   = differ && (cnt_q == CNT_LAST);
  // differ with sync high can only mean the level is about to rise
  assign RISE   = done & sync_q[1];
  assign LEVEL  = level_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], IN};
      if (!differ) begin
        cnt_q <= '0;
      end else if (done) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_event_port.sv
// Button event port: debounced levels plus sticky rising-edge flags that the
// CPU reads and clears with RD; INTR is raised while any flag is pending.
module btn_event_port
  import mcu_io_pkg::*;
#(
  parameter int DB_COUNT = DEFAULT_DB_COUNT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [NUM_BTN-1:0] LEVEL,
  btn_event_port_if.slave    cpu
);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] dout_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_bit
    debounce_bit #(
      .DB_COUNT(DB_COUNT)
    ) u_db (
      .CLK  (CLK),
      .RST  (RST),
      .IN   (BTN[i]),
      .LEVEL(LEVEL[i]),
      .RISE (rise[i])
    );
  end

  // a new event on the read edge survives the clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= '0;
    end else begin
      dout_q <= (cpu.RD ? '0 : dout_q) | rise;
    end
  end

  assign cpu.DOUT = dout_q;
  assign cpu.INTR = |dout_q;

endmodule

// File: tb/tb_btn_event_port.sv
// Scoreboard bench for btn_event_port with DB_COUNT=4: stimulus queues the
// expected output change and its edge number, a monitor pops on every change.
module tb_btn_event_port;
  import mcu_io_pkg::*;

  localparam int DB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN = 4'b0000;
  logic [3:0] LEVEL;

  btn_event_port_if cpu ();

  btn_event_port #(
    .DB_COUNT(DB)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN),
    .LEVEL(LEVEL),
    .cpu  (cpu)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] dout;
    logic       intr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] l, input logic [3:0] d, input logic i);
    exp_t e;
    e.cyc  = c;
    e.lvl  = l;
    e.dout = d;
    e.intr = i;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every change of the visible outputs must match the queue head
  logic [8:0] prev_o, cur_o;
  initial begin
    exp_t e;
    wait (mon_en);
    prev_o = {LEVEL, cpu.DOUT, cpu.INTR};
    forever begin
      @(posedge CLK);
      #1;
      cur_o = {LEVEL, cpu.DOUT, cpu.INTR};
      if (cur_o !== prev_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_change", 32'(cur_o), 32'(prev_o));
        end else begin
          e = sb.pop_front();
          chk("ev_cycle", 32'(cyc), 32'(e.cyc));
          chk("ev_level", 32'(LEVEL), 32'(e.lvl));
          chk("ev_dout",  32'(cpu.DOUT), 32'(e.dout));
          chk("ev_intr",  32'(cpu.INTR), 32'(e.intr));
        end
        prev_o = cur_o;
      end
    end
  end

  initial begin
    int c;
    cpu.RD = 1'b0;
    step(3);
    RST = 1'b0;
    step(1);
    chk("reset_level", 32'(LEVEL), 32'd0);
    chk("reset_dout",  32'(cpu.DOUT), 32'd0);
    chk("reset_intr",  32'(cpu.INTR), 32'd0);
    mon_en = 1'b1;
    step(2);

    // clean press of bit 0: edge 0 is c+1, update on edge c+1+DB+1
    c = cyc; BTN = 4'b0001; push(c + DB + 2, 4'b0001, 4'b0001, 1'b1);
    step(12); drain(20);

    // 3-cycle glitch on bit 2 must not be seen
    BTN = 4'b0101; step(3); BTN = 4'b0001;
    step(12);

    // bit 3 event lands on the same edge as RD: set wins over clear
    c = cyc; BTN = 4'b1001; push(c + DB + 2, 4'b1001, 4'b1000, 1'b1);
    step(DB + 1);
    chk("dout_before_sc", 32'(cpu.DOUT), 32'b0001);
    cpu.RD = 1'b1; step(1); cpu.RD = 1'b0;
    step(6); drain(20);

    // plain read clear; DOUT is still readable during the RD cycle
    c = cyc; cpu.RD = 1'b1;
    chk("dout_during_rd", 32'(cpu.DOUT), 32'b1000);
    push(c + 1, 4'b1001, 4'b0000, 1'b0);
    step(1); cpu.RD = 1'b0;
    step(6); drain(20);
    chk("level_held", 32'(LEVEL), 32'b1001);

    // RD with nothing pending changes nothing
    cpu.RD = 1'b1; step(1); cpu.RD = 1'b0; step(4);

    // release of bit 3 adds no event
    c = cyc; BTN = 4'b0001; push(c + DB + 2, 4'b0001, 4'b0000, 1'b0);
    step(10); drain(20);

    // 0001 -> 0110: two rises captured together, release of bit 0 ignored
    c = cyc; BTN = 4'b0110; push(c + DB + 2, 4'b0110, 4'b0110, 1'b1);
    step(10); drain(20);

    c = cyc; cpu.RD = 1'b1; push(c + 1, 4'b0110, 4'b0000, 1'b0);
    step(1); cpu.RD = 1'b0;
    step(3);

    c = cyc; BTN = 4'b0000; push(c + DB + 2, 4'b0000, 4'b0000, 1'b0);
    step(10); drain(20);

    // reset on edge 3 of a press abandons it; re-qualify from first post-reset edge
    c = cyc; BTN = 4'b0001;
    step(3); RST = 1'b1;
    step(1); RST = 1'b0;
    push(c + 5 + DB + 1, 4'b0001, 4'b0001, 1'b1);
    step(12); drain(20);

    // reset beats RD and clears live outputs; held button comes back
    c = cyc; RST = 1'b1; cpu.RD = 1'b1;
    push(c + 1, 4'b0000, 4'b0000, 1'b0);
    step(1); RST = 1'b0; cpu.RD = 1'b0;
    push(c + 2 + DB + 1, 4'b0001, 4'b0001, 1'b1);
    step(10); drain(20);

    chk("final_level", 32'(LEVEL), 32'b0001);
    chk("final_intr",  32'(cpu.INTR), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
